cnn_grid_sweeper: RTL and testbench
===================================

Name: cnn_grid_sweeper

Overview:
- Parametrised successor to the fixed 4x4 time-multiplexed cellular-network tile.
- Runs a GRID_N x GRID_N cellular nonlinear network on one shared 3x3 template cell, row-major, one cell per cycle.
- Runs a programmable number of synchronous (Jacobi) sweeps on internally stored U and Y arrays, using start/busy/done handshaking.
- Sits between the image loader and the readout logic; U is loaded through a write port and Y is read back through a registered read port.

Parameters:
WIDTH  16  signed fixed-point data width
FRAC  8  fractional bits; 1.0 = 1<<FRAC; requires WIDTH >= FRAC+2
GRID_N  4  grid side length; cell count N2 = GRID_N*GRID_N
ITER_W  8  width of iteration count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run; sampled only in IDLE
iterations  in  ITER_W  sweeps to run; sampled with start
a_tmpl  in  9*WIDTH  feedback template; k=0..8 row-major, k=4 centre, a_tmpl[k*WIDTH +: WIDTH]
b_tmpl  in  9*WIDTH  control template, same layout
bias  in  WIDTH  bias I
u_wr_en  in  1  U write strobe; ignored while busy
u_wr_addr  in  clog2(N2)  row-major cell index
u_wr_data  in  WIDTH  U value
y_rd_addr  in  clog2(N2)  readout cell index
y_rd_data  out  WIDTH  committed Y[y_rd_addr]; registered, 1-cycle latency
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
sweeps_done  out  ITER_W  sweeps executed in last run; valid from done

Behaviour:
- Reset: state IDLE; busy=0, done=0, sweeps_done=0, y_rd_data=0; U, Y and Ynext arrays all zero.
- Templates and bias must be held stable while busy; the block does not latch them.
- IDLE: start=1 latches iterations, clears Y and Ynext to zero, sets busy=1.
  - iterations=0: goes to FIN.
  - Otherwise: goes to SWEEP.
  - start while busy is ignored.
- SWEEP: issues cell index c=0..N2-1, one per cycle.
  - Stage 1 gathers the 3x3 neighbourhood of Y (committed) and U for c, forms 18 products and registers them.
  - Stage 2 sums the products plus (bias<<FRAC), then applies saturation, then writes Ynext[c].
- Neighbours outside the grid read as 0 (fixed zero boundary).
- Arithmetic:
  - Products are 2*WIDTH bits; the accumulator is 2*WIDTH+5 bits, and no overflow is possible.
  - Result = accumulator >>> FRAC (arithmetic shift, floor).
  - Output = clamp(result, -(1<<FRAC), +(1<<FRAC)), the standard piecewise-linear output.
- DRAIN: 2 cycles to flush the pipeline.
- COMMIT: 1 cycle; copies Ynext to Y and increments the sweep counter.
  - counter == iterations: goes to FIN.
  - Otherwise: returns to SWEEP.
- Y used within a sweep is always the previous committed Y; there is no in-sweep feedback.
- FIN: done=1 for one cycle, sweeps_done = counter, busy=0, then IDLE.
- Latency: done is high exactly iterations*(N2+3)+1 cycles after the start edge.
- y_rd_data always reflects committed Y, including while busy; it never shows partially computed Ynext.
- u_wr_en while busy: the write is dropped.
- Reset asserted mid-run: immediate return to reset state, with no done pulse.

Optional Feature:
- Macro: CNN_CONVERGE_EN.
- When defined: COMMIT also compares Ynext with Y. If no cell changed, the block goes to FIN early, even if counter < iterations; sweeps_done reports the sweeps actually executed.
- When undefined: always exactly `iterations` sweeps, and the comparison logic is absent.

Test Plan:
- N=4, FRAC=8, A=0, B centre=256, others 0, bias=0, U all 128, iterations=1 -> done 20 cycles after start; all Y=128; sweeps_done=1.
- Same templates, U cell0=512, cell1=-512 -> Y0=256, Y1=-256 (saturation both signs).
- B all nine=256, A=0, U all 16, iterations=1 -> corners 64, edges 96, interior 144 (zero boundary).
- A centre=512, B=0, bias=32, iterations=3 -> after each sweep, Y all = 32, then 96, then 224; done at cycle 58; only the final 224 is visible on readout after done.
- Reset pulsed mid-SWEEP of a 3-iteration run -> busy=0, no done, all y_rd_data=0; a new start runs normally. start while busy and u_wr_en while busy both have no effect.
- A centre=256, B=0, bias=0, iterations=5:
  - With CNN_CONVERGE_EN: done at cycle 20, sweeps_done=1.
  - Without CNN_CONVERGE_EN: done at cycle 96, sweeps_done=5.

Source files
------------

// File: rtl/cnn_grid_sweeper.sv
// cnn_grid_sweeper: GRID_N x GRID_N cellular nonlinear network evaluated on one shared 3x3 cell.
// Jacobi sweeps run row-major, one cell per cycle. Optional early exit on convergence: CNN_CONVERGE_EN.
module cnn_grid_sweeper #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 8,
    parameter int GRID_N = 4,
    parameter int ITER_W = 8,
    localparam int N2    = GRID_N * GRID_N,
    localparam int AW    = $clog2(N2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ITER_W-1:0]    iterations,
    input  logic [9*WIDTH-1:0]   a_tmpl,
    input  logic [9*WIDTH-1:0]   b_tmpl,
    input  logic [WIDTH-1:0]     bias,
    input  logic                 u_wr_en,
    input  logic [AW-1:0]        u_wr_addr,
    input  logic [WIDTH-1:0]     u_wr_data,
    input  logic [AW-1:0]        y_rd_addr,
    output logic [WIDTH-1:0]     y_rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [ITER_W-1:0]    sweeps_done
);

    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = 2 * WIDTH + 5;
    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(2 ** FRAC);
    localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

    typedef enum logic [2:0] {
        S_IDLE, S_SWEEP, S_DRAIN1, S_DRAIN2, S_COMMIT, S_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic [ITER_W-1:0]        cnt_q, cnt_d;
    logic [ITER_W-1:0]        swd_q, swd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [WIDTH-1:0]         y_rd_q, y_rd_d;
    logic                     s1_vld_q, s1_vld_d;
    logic [AW-1:0]            s1_addr_q, s1_addr_d;

    logic signed [WIDTH-1:0]  u_q  [N2];
    logic signed [WIDTH-1:0]  u_d  [N2];
    logic signed [WIDTH-1:0]  y_q  [N2];
    logic signed [WIDTH-1:0]  y_d  [N2];
    logic signed [WIDTH-1:0]  yn_q [N2];
    logic signed [WIDTH-1:0]  yn_d [N2];
    logic signed [PW-1:0]     prod_q [18];
    logic signed [PW-1:0]     prod_d [18];

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [WIDTH-1:0]  y_new;

    assign y_rd_data   = y_rd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sweeps_done = swd_q;

    // Stage 1: gather the 3x3 neighbourhood of committed Y and U; off-grid neighbours read as 0.
    always_comb begin
        int row, col, nr, nc;
        logic [AW-1:0] nb;
        logic signed [WIDTH-1:0] y_nb, u_nb, a_k, b_k;
        row = int'(idx_q) / GRID_N;
        col = int'(idx_q) % GRID_N;
        nr  = 0;
        nc  = 0;
        nb  = '0;
        y_nb = '0;
        u_nb = '0;
        a_k  = '0;
        b_k  = '0;
        for (int k = 0; k < 9; k++) begin
            nr   = row + k / 3 - 1;
            nc   = col + k % 3 - 1;
            nb   = '0;
            y_nb = '0;
            u_nb = '0;
            if (nr >= 0 && nr < GRID_N && nc >= 0 && nc < GRID_N) begin
                nb   = AW'(nr * GRID_N + nc);
                y_nb = y_q[nb];
                u_nb = u_q[nb];
            end
            a_k = a_tmpl[k*WIDTH +: WIDTH];
            b_k = b_tmpl[k*WIDTH +: WIDTH];
            prod_d[k]     = PW'(a_k) * PW'(y_nb);
            prod_d[9 + k] = PW'(b_k) * PW'(u_nb);
        end
    end

    // Stage 2: sum, floor-shift back to FRAC scale, then piecewise-linear clamp to [-1, +1].
    always_comb begin
        acc = ACC_W'($signed(bias)) <<< FRAC;
        for (int k = 0; k < 18; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        shifted = acc >>> FRAC;
        if (shifted > POS_LIM) begin
            y_new = POS_LIM[WIDTH-1:0];
        end else if (shifted < NEG_LIM) begin
            y_new = NEG_LIM[WIDTH-1:0];
        end else begin
            y_new = shifted[WIDTH-1:0];
        end
    end

`ifdef CNN_CONVERGE_EN
    logic changed;
    always_comb begin
        changed = 1'b0;
        for (int i = 0; i < N2; i++) begin
            if (yn_q[i] != y_q[i]) changed = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        cnt_d     = cnt_q;
        swd_d     = swd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        s1_vld_d  = 1'b0;
        s1_addr_d = idx_q;
        y_rd_d    = y_q[y_rd_addr];
        u_d       = u_q;
        y_d       = y_q;
        yn_d      = yn_q;

        if (u_wr_en && !busy_q) begin
            u_d[u_wr_addr] = u_wr_data;
        end
        if (s1_vld_q) begin
            yn_d[s1_addr_q] = y_new;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_d = iterations;
                    cnt_d  = '0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    for (int i = 0; i < N2; i++) begin
                        y_d[i]  = '0;
                        yn_d[i] = '0;
                    end
                    state_d = (iterations == '0) ? S_FIN : S_SWEEP;
                end
            end
            S_SWEEP: begin
                s1_vld_d = 1'b1;
                if (idx_q == AW'(N2 - 1)) begin
                    idx_d   = '0;
                    state_d = S_DRAIN1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_COMMIT;
            S_COMMIT: begin
                y_d   = yn_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == iter_q) begin
                    state_d = S_FIN;
`ifdef CNN_CONVERGE_EN
                end else if (!changed) begin
                    state_d = S_FIN;
`endif
                end else begin
                    state_d = S_SWEEP;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                swd_d   = cnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            iter_q    <= '0;
            cnt_q     <= '0;
            swd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            y_rd_q    <= '0;
            for (int i = 0; i < N2; i++) begin
                u_q[i]  <= '0;
                y_q[i]  <= '0;
                yn_q[i] <= '0;
            end
            for (int k = 0; k < 18; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            iter_q    <= iter_d;
            cnt_q     <= cnt_d;
            swd_q     <= swd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            y_rd_q    <= y_rd_d;
            u_q       <= u_d;
            y_q       <= y_d;
            yn_q      <= yn_d;
            prod_q    <= prod_d;
        end
    end

endmodule

// File: tb/tb_cnn_grid_sweeper.sv
// Scoreboard bench for cnn_grid_sweeper: a run/readout driver pushes expectations from a
// behavioural CNN model; a negedge monitor pops and compares on done and on readout data.
module tb_cnn_grid_sweeper;

    localparam int WIDTH  = 16;
    localparam int FRAC   = 8;
    localparam int GRID_N = 4;
    localparam int ITER_W = 8;
    localparam int N2     = GRID_N * GRID_N;
    localparam int AW     = $clog2(N2);
    localparam int ONE    = 1 << FRAC;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [ITER_W-1:0]   iterations = '0;
    logic [9*WIDTH-1:0]  a_tmpl = '0;
    logic [9*WIDTH-1:0]  b_tmpl = '0;
    logic [WIDTH-1:0]    bias = '0;
    logic                u_wr_en = 1'b0;
    logic [AW-1:0]       u_wr_addr = '0;
    logic [WIDTH-1:0]    u_wr_data = '0;
    logic [AW-1:0]       y_rd_addr = '0;
    logic [WIDTH-1:0]    y_rd_data;
    logic                busy;
    logic                done;
    logic [ITER_W-1:0]   sweeps_done;

    cnn_grid_sweeper #(.WIDTH(WIDTH), .FRAC(FRAC), .GRID_N(GRID_N), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iterations(iterations),
        .a_tmpl(a_tmpl), .b_tmpl(b_tmpl), .bias(bias),
        .u_wr_en(u_wr_en), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data),
        .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data),
        .busy(busy), .done(done), .sweeps_done(sweeps_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int sweeps; } run_exp_t;
    typedef struct { int cyc; int addr; int val; } rd_exp_t;
    run_exp_t run_q[$];
    rd_exp_t  rd_q[$];

    int checks = 0;
    int errors = 0;

    function void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    run_exp_t mon_run;
    rd_exp_t  mon_rd;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (run_q.size() == 0) begin
                check("unexpected_done", cyc, -1);
            end else begin
                mon_run = run_q.pop_front();
                check("done_cycle", cyc, mon_run.cyc);
                check("sweeps_done", sweeps_done, mon_run.sweeps);
                $display("run: done at cycle %0d sweeps_done=%0d", cyc, sweeps_done);
            end
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            mon_rd = rd_q.pop_front();
            check($sformatf("y_rd[%0d]", mon_rd.addr), $signed(y_rd_data), mon_rd.val);
        end
    end

    int a_i[9], b_i[9], bias_i;
    int mdl_u[N2], mdl_y[N2];

    task automatic apply_tmpl();
        for (int k = 0; k < 9; k++) begin
            a_tmpl[k*WIDTH +: WIDTH] = WIDTH'(a_i[k]);
            b_tmpl[k*WIDTH +: WIDTH] = WIDTH'(b_i[k]);
        end
        bias = WIDTH'(bias_i);
    endtask

    task automatic set_tmpl(input int a_c, input int b_c, input int b_rest, input int bi);
        for (int k = 0; k < 9; k++) begin
            a_i[k] = (k == 4) ? a_c : 0;
            b_i[k] = (k == 4) ? b_c : b_rest;
        end
        bias_i = bi;
        apply_tmpl();
    endtask

    task automatic load_u();
        for (int i = 0; i < N2; i++) begin
            @(negedge clk);
            u_wr_en   = 1'b1;
            u_wr_addr = AW'(i);
            u_wr_data = WIDTH'(mdl_u[i]);
        end
        @(negedge clk);
        u_wr_en = 1'b0;
    endtask

    // Reference: Jacobi CNN update on whole arrays with zero boundary and PWL output.
    task automatic model_run(input int iter, output int sw);
        longint y[N2], yn[N2], acc, v;
        int nr, nc;
        for (int i = 0; i < N2; i++) begin y[i] = 0; yn[i] = 0; end
        sw = 0;
        for (int s = 0; s < iter; s++) begin
            for (int r = 0; r < GRID_N; r++) begin
                for (int c = 0; c < GRID_N; c++) begin
                    acc = longint'(bias_i) * ONE;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            nr = r + dr;
                            nc = c + dc;
                            if (nr >= 0 && nr < GRID_N && nc >= 0 && nc < GRID_N) begin
                                acc += longint'(a_i[(dr+1)*3 + dc + 1]) * y[nr*GRID_N + nc];
                                acc += longint'(b_i[(dr+1)*3 + dc + 1]) * mdl_u[nr*GRID_N + nc];
                            end
                        end
                    end
                    v = acc >>> FRAC;
                    if (v > ONE) v = ONE;
                    if (v < -ONE) v = -ONE;
                    yn[r*GRID_N + c] = v;
                end
            end
            sw++;
`ifdef CNN_CONVERGE_EN
            begin
                bit same;
                same = 1'b1;
                for (int i = 0; i < N2; i++) if (yn[i] != y[i]) same = 1'b0;
                for (int i = 0; i < N2; i++) y[i] = yn[i];
                if (same) break;
            end
`else
            for (int i = 0; i < N2; i++) y[i] = yn[i];
`endif
        end
        for (int i = 0; i < N2; i++) mdl_y[i] = int'(y[i]);
    endtask

    task automatic run(input int iter, output int start_cyc);
        int sw;
        run_exp_t e;
        model_run(iter, sw);
        @(negedge clk);
        start      = 1'b1;
        iterations = ITER_W'(iter);
        start_cyc  = cyc + 1;
        e.cyc      = start_cyc + sw * (N2 + 3) + 1;
        e.sweeps   = sw;
        run_q.push_back(e);
        $display("run: start iterations=%0d at cycle %0d, expect done at %0d", iter, start_cyc, e.cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (run_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (run_q.size() > 0) begin
            check("done_timeout", run_q.size(), 0);
            run_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic read_one(input int addr, input int val);
        rd_exp_t t;
        @(negedge clk);
        y_rd_addr = AW'(addr);
        t.cyc  = cyc + 1;
        t.addr = addr;
        t.val  = val;
        rd_q.push_back(t);
    endtask

    task automatic read_all();
        for (int i = 0; i < N2; i++) read_one(i, mdl_y[i]);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sweeps_done", sweeps_done, 0);
        check("reset_y_rd", y_rd_data, 0);
        rst_n = 1'b1;
        for (int i = 0; i < N2; i++) begin mdl_u[i] = 0; mdl_y[i] = 0; end
        read_all();

        // Pass-through with busy-time start and U write both ignored.
        set_tmpl(0, 256, 0, 0);
        for (int i = 0; i < N2; i++) mdl_u[i] = 128;
        load_u();
        run(1, sc);
        wait_until(sc + 3);
        check("busy_during_run", busy, 1);
        start = 1'b1; iterations = ITER_W'(7);
        u_wr_en = 1'b1; u_wr_addr = AW'(10); u_wr_data = WIDTH'(999);
        @(negedge clk);
        start = 1'b0; u_wr_en = 1'b0;
        wait_done();
        read_all();

        // Saturation in both directions.
        mdl_u[0] = 512; mdl_u[1] = -512;
        load_u();
        run(1, sc);
        wait_done();
        read_all();

        // Zero-boundary neighbourhood sums.
        set_tmpl(0, 256, 256, 0);
        for (int i = 0; i < N2; i++) mdl_u[i] = 16;
        load_u();
        run(1, sc);
        wait_done();
        read_all();

        // Feedback with bias over 3 sweeps; readout mid-run shows only committed Y.
        set_tmpl(512, 0, 0, 32);
        run(3, sc);
        read_one(5, 0);
        wait_until(sc + 25);
        read_one(6, 32);
        wait_done();
        read_all();

        // Zero iterations: immediate finish with cleared Y.
        run(0, sc);
        wait_done();
        read_all();

        // Reset mid-sweep: no done, everything back to zero.
        set_tmpl(0, 256, 0, 0);
        for (int i = 0; i < N2; i++) mdl_u[i] = 100 + i;
        load_u();
        @(negedge clk);
        start = 1'b1; iterations = ITER_W'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_sweeps_done", sweeps_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < N2; i++) begin mdl_u[i] = 0; mdl_y[i] = 0; end
        read_all();
        for (int i = 0; i < N2; i++) mdl_u[i] = 128;
        load_u();
        run(1, sc);
        wait_done();
        read_all();

        // Identity feedback from zero state: converges immediately when enabled.
        set_tmpl(256, 0, 0, 0);
        run(5, sc);
        wait_done();
        read_all();

        // Randomised templates, inputs and iteration counts.
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 9; k++) begin
                a_i[k] = int'($urandom_range(600)) - 300;
                b_i[k] = int'($urandom_range(600)) - 300;
            end
            bias_i = int'($urandom_range(128)) - 64;
            apply_tmpl();
            for (int i = 0; i < N2; i++) mdl_u[i] = int'($urandom_range(1200)) - 600;
            load_u();
            run(int'($urandom_range(3, 1)), sc);
            wait_done();
            read_all();
        end

        check("scoreboard_run_empty", run_q.size(), 0);
        check("scoreboard_rd_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
